// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 (or 8E1 when UART_RX_PARITY_EN is defined),
// LSB first, with start-bit glitch rejection, framing-error and break handling.
module uart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic             rx_meta_q, rx_sync_q;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             tick;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif

  assign tick = (div_cnt_q == DIV_MAX);

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d   = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_ready_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = 1'b0;
`endif
        // Restarting the divider here aligns every later tick to the start edge.
        if (!rx_sync_q) begin
          state_d   = S_START;
          div_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick && tick_cnt_q == 4'd7) begin
          tick_cnt_d = '0;
          state_d    = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && tick_cnt_q == 4'd15) begin
          shift_d[bit_idx_q] = rx_sync_q;
          tick_cnt_d         = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && tick_cnt_q == 4'd15) begin
          tick_cnt_d   = '0;
          par_bad_d    = (rx_sync_q != ^shift_q);
          parity_err_d = (rx_sync_q != ^shift_q);
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick && tick_cnt_q == 4'd15) begin
          tick_cnt_d = '0;
          if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
              rx_data_d  = shift_q;
              rx_ready_d = 1'b1;
            end
`else
            rx_data_d  = shift_q;
            rx_ready_d = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        tick_cnt_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit and the outputs
// are scored against a frame-level model (expected byte queue and pulse counts).
module tb_uart_rx;

  localparam int CLK_FREQ = 7372800;
  localparam int BAUD     = 115200;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  // Observed behaviour, collected at every falling edge.
  logic [7:0] got_q[$];
  int n_ready, n_ferr, n_perr, n_overlap, n_long;
  logic prev_ready = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

  // Frame-level reference model.
  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  int exp_ferr, exp_perr;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_ready) begin
      got_q.push_back(rx_data);
      n_ready++;
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (int'(rx_ready) + int'(frame_err) + int'(parity_err) > 1) n_overlap++;
    if ((rx_ready && prev_ready) || (frame_err && prev_ferr) || (parity_err && prev_perr)) n_long++;
    prev_ready = rx_ready;
    prev_ferr  = frame_err;
    prev_perr  = parity_err;
  end

  task automatic clear_scores();
    exp_q.delete();
    got_q.delete();
    n_ready = 0; n_ferr = 0; n_perr = 0; n_overlap = 0; n_long = 0;
    exp_ferr = 0; exp_perr = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good_stop, input bit bad_par);
    if (!good_stop) exp_ferr++;
    if (PAR_EN && bad_par) exp_perr++;
    if (good_stop && !(PAR_EN && bad_par)) begin
      exp_q.push_back(b);
      exp_last = b;
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit bad_par);
    model_frame(b, good_stop, bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_EN) send_bit((^b) ^ bad_par);
    send_bit(good_stop);
  endtask

  task automatic test_reset();
    clear_scores();
    exp_last = 8'h00;
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({rx_data, rx_ready, frame_err, parity_err} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%h rdy=%b ferr=%b perr=%b expected 00/0/0/0",
               rx_data, rx_ready, frame_err, parity_err);
    end
    reset = 1'b0;
    idle_bits(2);
    checks++;
    if (n_ready + n_ferr + n_perr !== 0) begin
      errors++;
      $display("[TB] FAIL reset_quiet: got %0d pulses expected 0", n_ready + n_ferr + n_perr);
    end
  endtask

  // Shared scoring body, written out in each scenario task.
  task automatic test_single();
    clear_scores();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (n_ferr !== exp_ferr || n_perr !== exp_perr) begin errors++; $display("[TB] FAIL single_errs: got ferr=%0d perr=%0d expected %0d/%0d", n_ferr, n_perr, exp_ferr, exp_perr); end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("[TB] FAIL single_hold: got %h expected %h", rx_data, exp_last); end
  endtask

  task automatic test_back_to_back();
    clear_scores();
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h43, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (n_ferr !== exp_ferr || n_perr !== exp_perr || n_overlap !== 0 || n_long !== 0) begin
      errors++; $display("[TB] FAIL b2b_pulses: got ferr=%0d perr=%0d ovl=%0d long=%0d expected %0d/%0d/0/0", n_ferr, n_perr, n_overlap, n_long, exp_ferr, exp_perr);
    end
  endtask

  task automatic test_glitch();
    clear_scores();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle_bits(2);
    checks++;
    if (n_ready + n_ferr + n_perr !== 0) begin errors++; $display("[TB] FAIL glitch_quiet: got %0d pulses expected 0", n_ready + n_ferr + n_perr); end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL glitch_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL glitch_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (n_ferr !== exp_ferr || n_perr !== exp_perr) begin errors++; $display("[TB] FAIL glitch_errs: got ferr=%0d perr=%0d expected %0d/%0d", n_ferr, n_perr, exp_ferr, exp_perr); end
  endtask

  task automatic test_break();
    clear_scores();
    send_frame(8'h55, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if (n_ready !== 0 || n_ferr !== exp_ferr || n_long !== 0) begin
      errors++; $display("[TB] FAIL break_pulses: got rdy=%0d ferr=%0d long=%0d expected 0/%0d/0", n_ready, n_ferr, n_long, exp_ferr);
    end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("[TB] FAIL break_hold: got %h expected %h", rx_data, exp_last); end
    idle_bits(1);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL break_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL break_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_midframe_reset();
    clear_scores();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    exp_last = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLKS / 2 - 3) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle_bits(2);
    checks++;
    if (n_ready + n_ferr + n_perr !== 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d pulses expected 0", n_ready + n_ferr + n_perr); end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("[TB] FAIL abort_data: got %h expected %h", rx_data, exp_last); end
    send_frame(8'h12, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL abort_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL abort_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    clear_scores();
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, ($urandom_range(0, 3) == 0));
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", n_ready, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (n_ferr !== exp_ferr || n_perr !== exp_perr || n_overlap !== 0 || n_long !== 0) begin
      errors++; $display("[TB] FAIL rand_pulses: got ferr=%0d perr=%0d ovl=%0d long=%0d expected %0d/%0d/0/0", n_ferr, n_perr, n_overlap, n_long, exp_ferr, exp_perr);
    end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("[TB] FAIL rand_hold: got %h expected %h", rx_data, exp_last); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_scores();
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    checks++;
    if (n_perr !== exp_perr || n_ready !== 0) begin errors++; $display("[TB] FAIL parity_bad: got perr=%0d rdy=%0d expected %0d/0", n_perr, n_ready, exp_perr); end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("[TB] FAIL parity_hold: got %h expected %h", rx_data, exp_last); end
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (n_ready !== exp_q.size() || n_perr !== exp_perr) begin errors++; $display("[TB] FAIL parity_good: got rdy=%0d perr=%0d expected %0d/%0d", n_ready, n_perr, exp_q.size(), exp_perr); end
    checks++;
    if (rx_data !== 8'h07) begin errors++; $display("[TB] FAIL parity_data: got %h expected 07", rx_data); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_midframe_reset();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-006 Port rx_data  output  8  last correctly framed byte; held until the next valid byte.
REQ-007 Port rx_ready  output  1  one-cycle pulse; rx_data is valid and new in that cycle.
REQ-008 Port frame_err  output  1  one-cycle pulse on a stop bit sampled low.
REQ-009 Port parity_err  output  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

Function
REQ-010 rx shall pass through a 2-flop synchronizer, both flops reset to 1, before any use.
REQ-011 Oversample tick: divisor DIV = CLK_FREQ/(BAUD_RATE*16), integer-truncated (54 at defaults); counter counts 0..DIV-1 and pulses tick for 1 cycle at DIV-1.
REQ-012 The tick counter shall restart at 0 on the IDLE->START transition so sampling aligns to the start-bit edge.
REQ-013 States: IDLE, START, DATA, PARITY (only when compiled in), STOP, BREAK.
REQ-014 IDLE: on synchronized rx=0 go to START and clear the tick-count and bit-index counters.
REQ-015 START: after 8 ticks (mid-bit) sample rx; 0 -> DATA; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: every 16 ticks sample rx into shift register bit[index], LSB first; after index 7 go to PARITY if enabled, else STOP.
REQ-017 STOP: after 16 ticks sample rx; 1 -> load rx_data, pulse rx_ready the following cycle, go to IDLE; 0 -> pulse frame_err, leave rx_data unchanged, go to BREAK.
REQ-018 BREAK: remain until synchronized rx=1, then IDLE; no new frame shall start while in BREAK.
REQ-019 rx_ready, frame_err and parity_err shall never assert in the same cycle and never last more than 1 cycle.
REQ-020 Back-to-back frames (stop bit followed immediately by a start bit) shall be received with no lost byte; minimum spacing between rx_ready pulses is one frame time.
REQ-021 Tick-count and bit-index counters shall not wrap mid-frame; each counter resets on every state change.

Reset
REQ-022 On reset: state=IDLE, rx_data=8'h00, rx_ready=0, frame_err=0, parity_err=0, all counters 0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame shall abort the frame with no output pulse; after release the block waits in IDLE for a new falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, frame is 8E1; the PARITY state samples the bit 16 ticks after bit 7 and compares it to the XOR of the 8 data bits (even parity).
REQ-025 With UART_RX_PARITY_EN, a mismatch shall pulse parity_err, suppress rx_ready, leave rx_data unchanged, and the block still proceeds to STOP for framing.
REQ-026 Without UART_RX_PARITY_EN: no PARITY state, frame is 8N1, parity_err tied 0.

Verification
REQ-027 Defaults, send 8'hA5 8N1 at 115200 -> one rx_ready pulse, rx_data=8'hA5, no error pulses.
REQ-028 Send 8'h41, 8'h42, 8'h43 back-to-back -> three rx_ready pulses with rx_data 41,42,43 in order.
REQ-029 2-clock low glitch on idle rx -> START aborts; no pulses; the next frame 8'h3C is received correctly.
REQ-030 Frame 8'h55 with the stop bit held low for 3 bit times -> frame_err pulse once, rx_data keeps its previous value, no reception until rx returns high, then 8'h0F is received.
REQ-031 Reset asserted during bit 4 of 8'hFF -> no pulses, rx_data=8'h00; the following frame 8'h12 is received.
REQ-032 With UART_RX_PARITY_EN, 8'h07 sent with parity bit 0 (wrong) -> parity_err pulse, no rx_ready; with parity bit 1 -> rx_ready, rx_data=8'h07.
